ddcb_delay_calibrator: RTL



---
 rtl/ddcb_delay_calibrator.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ddcb_delay_calibrator.sv
// Delay-line calibration controller: thermometer sweep, settle, majority vote, lock/fail.
// Optional DDCB_TRACK_EN: keep voting while locked and nudge the tap by one toward the edge.
module ddcb_delay_calibrator #(
    parameter int unsigned Nmbr_cascades = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned VOTE_CYCLES   = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   phase_late,
    input  logic                                   cfg_manual,
    input  logic [$clog2(Nmbr_cascades+1)-1:0]     cfg_tap,
    output logic [Nmbr_cascades-1:0]               select,
    output logic [$clog2(Nmbr_cascades+1)-1:0]     tap,
    output logic                                   busy,
    output logic                                   locked,
    output logic                                   fail
);

    localparam int unsigned TapW   = $clog2(Nmbr_cascades + 1);
    localparam int unsigned OnesW  = $clog2(VOTE_CYCLES + 1);
    localparam int unsigned CntMax = (SETTLE_CYCLES > VOTE_CYCLES) ? SETTLE_CYCLES : VOTE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [TapW-1:0]  TapMax     = TapW'(Nmbr_cascades);
    localparam logic [OnesW-1:0] HalfVotes  = OnesW'(VOTE_CYCLES / 2);
    localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0]  VoteLast   = CntW'(VOTE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StVote,
        StDecide,
        StLocked,
        StFail
    } state_e;

    state_e                   state_q, state_d;
    logic [TapW-1:0]          tap_q, tap_d;
    logic [Nmbr_cascades-1:0] select_q, select_d;
    logic                     busy_q, busy_d;
    logic                     locked_q, locked_d;
    logic                     fail_q, fail_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [OnesW-1:0]         ones_q, ones_d;

    logic [TapW-1:0] manual_tap;
    logic            settle_done;
    logic            vote_done;
    logic            decide_late;

    function automatic logic [Nmbr_cascades-1:0] therm(input logic [TapW-1:0] t);
        logic [Nmbr_cascades-1:0] v;
        for (int unsigned i = 0; i < Nmbr_cascades; i++) begin
            v[i] = (i < 32'(t));
        end
        return v;
    endfunction

    assign manual_tap  = (cfg_tap > TapMax) ? TapMax : cfg_tap;
    assign settle_done = (cnt_q == SettleLast);
    assign vote_done   = (cnt_q == VoteLast);
    // A tie is not a late decision.
    assign decide_late = (ones_q > HalfVotes);

`ifdef DDCB_TRACK_EN
    logic [OnesW-1:0] track_ones;
    logic             track_late;
    logic             track_step;

    // The tracking window decides on the cycle of its last sample, so fold that sample in.
    assign track_ones = ones_q + OnesW'(phase_late);
    assign track_late = (track_ones > HalfVotes);
    assign track_step = (track_late && (tap_q != '0)) || (!track_late && (tap_q != TapMax));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            tap_q    <= '0;
            select_q <= '0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
            cnt_q    <= '0;
            ones_q   <= '0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            select_q <= select_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cfg_manual) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StFail: begin
                    if (start) state_d = StApply;
                end
                StLocked: begin
                    if (start) begin
                        state_d = StApply;
                    end
`ifdef DDCB_TRACK_EN
                    else if (vote_done && track_step) begin
                        state_d = StApply;
                    end
`endif
                end
                StApply: state_d = StSettle;
                StSettle: begin
                    if (settle_done) begin
`ifdef DDCB_TRACK_EN
                        state_d = locked_q ? StLocked : StVote;
`else
                        state_d = StVote;
`endif
                    end
                end
                StVote: begin
                    if (vote_done) state_d = StDecide;
                end
                StDecide: begin
                    if (decide_late)          state_d = StLocked;
                    else if (tap_q == TapMax) state_d = StFail;
                    else                      state_d = StApply;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        tap_d    = tap_q;
        select_d = select_q;
        busy_d   = busy_q;
        locked_d = locked_q;
        fail_d   = fail_q;
        cnt_d    = cnt_q;
        ones_d   = ones_q;
        if (cfg_manual) begin
            tap_d    = manual_tap;
            select_d = therm(manual_tap);
            busy_d   = 1'b0;
            locked_d = 1'b0;
            fail_d   = 1'b0;
            cnt_d    = '0;
            ones_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StFail, StLocked: begin
                    if (start) begin
                        tap_d    = '0;
                        busy_d   = 1'b1;
                        locked_d = 1'b0;
                        fail_d   = 1'b0;
                        cnt_d    = '0;
                        ones_d   = '0;
                    end
`ifdef DDCB_TRACK_EN
                    else if (state_q == StLocked) begin
                        ones_d = track_ones;
                        cnt_d  = cnt_q + CntW'(1);
                        if (vote_done) begin
                            cnt_d  = '0;
                            ones_d = '0;
                            if (track_late && (tap_q != '0)) begin
                                tap_d = tap_q - TapW'(1);
                            end else if (!track_late && (tap_q != TapMax)) begin
                                tap_d = tap_q + TapW'(1);
                            end
                        end
                    end
`endif
                end
                StApply: begin
                    select_d = therm(tap_q);
                    cnt_d    = '0;
                    ones_d   = '0;
                end
                StSettle: begin
                    cnt_d  = settle_done ? '0 : cnt_q + CntW'(1);
                    ones_d = '0;
                end
                StVote: begin
                    ones_d = ones_q + OnesW'(phase_late);
                    cnt_d  = vote_done ? '0 : cnt_q + CntW'(1);
                end
                StDecide: begin
                    cnt_d  = '0;
                    ones_d = '0;
                    if (decide_late) begin
                        locked_d = 1'b1;
                        busy_d   = 1'b0;
                    end else if (tap_q == TapMax) begin
                        fail_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        tap_d = tap_q + TapW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign select = select_q;
    assign tap    = tap_q;
    assign busy   = busy_q;
    assign locked = locked_q;
    assign fail   = fail_q;

endmodule
